rlight_led_fader: RTL and testbench
===================================

Name: rlight_led_fader

Overview:
- Output stage downstream of the running-light peripheral. Consumes its 8-bit LED pattern and drives the physical LED pins.
- Each LED gets a per-channel brightness level rendered as PWM.
- A lit bit loads full brightness. When a bit clears, the LED fades out at a programmable rate, producing a "comet trail" behind the running light.
- Configuration inputs are driven from the peripheral's register file.

Parameters:
- NumLeds, 8, number of LED channels.
- PwmW, 8, brightness/PWM counter width; one PWM frame = 2**PwmW cycles.
- DivW, 16, width of the decay frame divider.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  block enable.
- pattern_i  in  NumLeds  LED pattern from the running-light stage; bit k = LED k on.
- max_level_i  in  PwmW  global brightness for lit LEDs.
- decay_step_i  in  PwmW  amount subtracted from a level per decay tick.
- decay_div_i  in  DivW  decay tick occurs once every decay_div_i+1 frames.
- led_o  out  NumLeds  PWM LED drive, registered.
- frame_o  out  1  one-cycle pulse on the last cycle of each PWM frame.

Behaviour:
- Reset (rst_i=1 at a clock edge): pwm_cnt=0, decay_cnt=0, all level[k]=0, led_o=0, frame_o=0.
- en_i=0 has the same effect as reset on the next edge:
  - counters and levels cleared, outputs 0;
  - inputs ignored.
- pwm_cnt (PwmW bits), when en_i=1:
  - increments every cycle, wraps all-ones -> 0;
  - frame_o = registered (en_i && pwm_cnt==all-ones), asserted exactly once per 2**PwmW cycles.
- Frame boundary = the cycle where pwm_cnt==all-ones. level and decay_cnt update only at frame boundaries, so there are no mid-frame duty glitches. pattern_i/config changes mid-frame take effect at the next boundary.
- decay_cnt, at each boundary:
  - if decay_cnt==decay_div_i: decay_tick=1, decay_cnt<=0;
  - else decay_cnt<=decay_cnt+1;
  - decay_div_i=0 means a tick every frame;
  - if decay_div_i is lowered below the current decay_cnt, the compare misses and decay_cnt wraps through 2**DivW. This is accepted; software writes the divider while the block is disabled.
- level[k] update at each boundary, priority order:
  1. pattern_i[k]=1: level<=max_level_i. Load beats decay when both occur in the same boundary.
  2. else, level>max_level_i: level<=max_level_i (clamp after a brightness reduction).
  3. else, decay_tick: level<=level-decay_step_i, saturating at 0 (no wrap). decay_step_i=0 holds the level.
  4. else hold.
- First frame after enable: levels stay 0 until the first boundary.
- led_o[k] <= en_i && (pwm_cnt < level[k]), registered, so one cycle of latency from pwm_cnt.
  - Duty = level/2**PwmW.
  - level 0 = always off; max 255/256 on (PwmW=8).
- All arithmetic is unsigned. The compare and saturation use PwmW+1-bit intermediates.
- Reset or enable drop mid-frame: led_o goes to 0 on the next edge. No partial-frame state is retained.

Decomposition:
- Shared package rlight_pkg holds:
  - default widths (NumLeds, PwmW, DivW);
  - typedef level_t = logic [PwmW-1:0];
  - the existing register offsets and MODE_* encodings, with new register offsets for MAX_LEVEL, DECAY_STEP, DECAY_DIV.
- One sub-module, rlight_fade_channel, instantiated NumLeds times:
  - inputs: frame strobe, decay_tick, pattern bit, config, pwm_cnt;
  - holds level[k];
  - produces the registered led bit.
- The top holds pwm_cnt, decay_cnt and frame_o.

Test Plan:
- Steady on: rst_i pulse, en_i=1, pattern_i=0x01, max_level_i=0x80, decay_step_i=0 -> from frame 2 on, led_o[0] high exactly 128 of every 256 cycles; led_o[7:1]=0; frame_o every 256 cycles.
- Fade: after the level reaches 0x80, set pattern_i=0x00, decay_step_i=0x40, decay_div_i=0 -> led_o[0] duty per frame 64, 0, 0; never wraps back up.
- Saturation + divider: level 0x30, decay_step_i=0x40, decay_div_i=2 -> level stays 0x30 for 2 frames, then 0x00 on the 3rd boundary; duty 48, 48, 0.
- Priority: pattern_i[3]=1 in the same boundary as a decay tick -> level[3]=max_level_i. Lowering max_level_i 0xFF->0x10 while bit 2 is off with level 0xFF -> level[2] clamps to 0x10 at the next boundary.
- Mid-frame change: toggle pattern_i 0x01->0x02 at pwm_cnt=0x40 -> led_o pattern unchanged until the boundary, new channel lights in the following frame.
- Reset/enable mid-operation: assert rst_i (then separately drop en_i) at pwm_cnt=0x20 with levels non-zero -> next cycle led_o=0, frame_o=0; after release, the first frame_o arrives 256 cycles later and all levels restart at 0.

Source files
------------

// File: rtl/rlight_pkg.sv
// Shared definitions for the running-light peripheral and its LED fader output stage.
// Holds default widths, common types and the register map.
package rlight_pkg;

    localparam int DefNumLeds = 8;
    localparam int DefPwmW    = 8;
    localparam int DefDivW    = 16;

    typedef logic [DefPwmW-1:0] level_t;

    typedef enum logic [1:0] {
        MODE_SHIFT_LEFT  = 2'd0,
        MODE_SHIFT_RIGHT = 2'd1,
        MODE_BOUNCE      = 2'd2,
        MODE_STATIC      = 2'd3
    } mode_e;

    // Byte offsets into the peripheral register file; the last three feed the fader.
    localparam logic [7:0] REG_CTRL       = 8'h00;
    localparam logic [7:0] REG_MODE       = 8'h04;
    localparam logic [7:0] REG_PERIOD     = 8'h08;
    localparam logic [7:0] REG_PATTERN    = 8'h0C;
    localparam logic [7:0] REG_MAX_LEVEL  = 8'h10;
    localparam logic [7:0] REG_DECAY_STEP = 8'h14;
    localparam logic [7:0] REG_DECAY_DIV  = 8'h18;

endpackage

// File: rtl/rlight_fade_channel.sv
// One LED channel: holds its brightness level, updates it only at frame boundaries,
// and renders it as a registered PWM bit against the shared PWM counter.
module rlight_fade_channel
    import rlight_pkg::*;
#(
    parameter int PwmW = DefPwmW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            frame_i,
    input  logic            decay_tick_i,
    input  logic            pattern_i,
    input  logic [PwmW-1:0] max_level_i,
    input  logic [PwmW-1:0] decay_step_i,
    input  logic [PwmW-1:0] pwm_cnt_i,
    output logic            led_o
);

    logic [PwmW-1:0] r_level;
    logic            r_led;

    logic [PwmW:0]   w_diff;
    logic [PwmW-1:0] w_decayed;
    logic            w_on;

    // Borrow out of the extended subtraction means the step overshot zero.
    assign w_diff    = {1'b0, r_level} - {1'b0, decay_step_i};
    assign w_decayed = w_diff[PwmW] ? '0 : w_diff[PwmW-1:0];
    assign w_on      = ({1'b0, pwm_cnt_i} < {1'b0, r_level});

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_level <= '0;
            r_led   <= 1'b0;
        end else begin
            r_led <= w_on;
            if (frame_i) begin
                if (pattern_i) begin
                    r_level <= max_level_i;
                end else if (r_level > max_level_i) begin
                    r_level <= max_level_i;
                end else if (decay_tick_i) begin
                    r_level <= w_decayed;
                end
            end
        end
    end

    assign led_o = r_led;

endmodule

// File: rtl/rlight_led_fader.sv
// LED output stage: shared PWM frame counter and decay divider driving one
// fade channel per LED, producing a fading "comet trail" behind the running light.
module rlight_led_fader
    import rlight_pkg::*;
#(
    parameter int NumLeds = DefNumLeds,
    parameter int PwmW    = DefPwmW,
    parameter int DivW    = DefDivW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NumLeds-1:0] pattern_i,
    input  logic [PwmW-1:0]    max_level_i,
    input  logic [PwmW-1:0]    decay_step_i,
    input  logic [DivW-1:0]    decay_div_i,
    output logic [NumLeds-1:0] led_o,
    output logic               frame_o
);

    logic [PwmW-1:0]    r_pwm_cnt;
    logic [DivW-1:0]    r_decay_cnt;
    logic               r_frame;

    logic               w_boundary;
    logic               w_decay_tick;
    logic [NumLeds-1:0] w_led;

    // Levels and divider only move on the last cycle of a frame, so duty never glitches mid-frame.
    assign w_boundary   = (r_pwm_cnt == '1);
    assign w_decay_tick = w_boundary && (r_decay_cnt == decay_div_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_pwm_cnt   <= '0;
            r_decay_cnt <= '0;
            r_frame     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_frame   <= w_boundary;
            if (w_boundary) begin
                if (w_decay_tick) begin
                    r_decay_cnt <= '0;
                end else begin
                    r_decay_cnt <= r_decay_cnt + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NumLeds; gi++) begin : g_chan
            rlight_fade_channel #(
                .PwmW (PwmW)
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .en_i         (en_i),
                .frame_i      (w_boundary),
                .decay_tick_i (w_decay_tick),
                .pattern_i    (pattern_i[gi]),
                .max_level_i  (max_level_i),
                .decay_step_i (decay_step_i),
                .pwm_cnt_i    (r_pwm_cnt),
                .led_o        (w_led[gi])
            );
        end
    endgenerate

    assign led_o   = w_led;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_rlight_led_fader.sv
// Directed bench for rlight_led_fader: measures per-frame LED duty and frame timing
// against hand-computed values.
module tb_rlight_led_fader;

    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  pattern;
    logic [7:0]  max_level;
    logic [7:0]  decay_step;
    logic [15:0] decay_div;
    logic [7:0]  led;
    logic        frame;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt[NL];
    int tot;
    int n_first;
    int n_lit;

    always #5 clk = ~clk;

    rlight_led_fader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .pattern_i    (pattern),
        .max_level_i  (max_level),
        .decay_step_i (decay_step),
        .decay_div_i  (decay_div),
        .led_o        (led),
        .frame_o      (frame)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Counts LED-high samples over the 256 samples following an aligned frame_o sample.
    task automatic count_frame(input string tag, input int chg_idx, input logic [7:0] chg_pat);
        int hits;
        int last;
        hits = 0;
        last = 0;
        tot  = 0;
        for (int k = 0; k < NL; k++) cnt[k] = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            for (int k = 0; k < NL; k++) if (led[k]) cnt[k]++;
            if (frame) begin
                hits++;
                last = i;
            end
            if (i == chg_idx) pattern = chg_pat;
        end
        for (int k = 0; k < NL; k++) tot += cnt[k];
        check_eq({tag, "_frame_hits"}, hits, 1);
        check_eq({tag, "_frame_pos"}, last, 256);
    endtask

    task automatic wait_first_frame(output int n, output int lit);
        n   = 0;
        lit = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (frame) begin
                n = i;
                break;
            end
            lit += $countones(led);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        pattern    = 8'h01;
        max_level  = 8'h80;
        decay_step = 8'h00;
        decay_div  = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_led", led, 0);
        check_eq("rst_frame", frame, 0);

        // Steady on
        rst = 1'b0;
        wait_first_frame(n_first, n_lit);
        check_eq("first_frame_lat", n_first, 256);
        check_eq("first_frame_dark", n_lit, 0);
        count_frame("steady1", 0, 8'h00);
        check_eq("steady1_led0", cnt[0], 128);
        check_eq("steady1_total", tot, 128);
        count_frame("steady2", 0, 8'h00);
        check_eq("steady2_led0", cnt[0], 128);
        check_eq("steady2_total", tot, 128);

        // Fade, tick every frame
        pattern    = 8'h00;
        decay_step = 8'h40;
        decay_div  = 16'd0;
        count_frame("fade0", 0, 8'h00);
        check_eq("fade0_led0", cnt[0], 128);
        count_frame("fade1", 0, 8'h00);
        check_eq("fade1_led0", cnt[0], 64);
        count_frame("fade2", 0, 8'h00);
        check_eq("fade2_led0", cnt[0], 0);
        count_frame("fade3", 0, 8'h00);
        check_eq("fade3_total", tot, 0);

        // Saturation with divider of 3 frames
        pattern   = 8'h01;
        max_level = 8'h30;
        decay_div = 16'd2;
        count_frame("sat_load", 0, 8'h00);
        check_eq("sat_load_led0", cnt[0], 0);
        pattern = 8'h00;
        count_frame("sat1", 0, 8'h00);
        check_eq("sat1_led0", cnt[0], 48);
        count_frame("sat2", 0, 8'h00);
        check_eq("sat2_led0", cnt[0], 48);
        count_frame("sat3", 0, 8'h00);
        check_eq("sat3_led0", cnt[0], 0);

        // Priority: reprogram divider while disabled, load wins over a tick
        en         = 1'b0;
        pattern    = 8'h0C;
        max_level  = 8'hFF;
        decay_step = 8'h40;
        decay_div  = 16'd0;
        @(negedge clk);
        en = 1'b1;
        wait_first_frame(n_first, n_lit);
        check_eq("prio_lat", n_first, 256);
        count_frame("prio_load", 0, 8'h00);
        check_eq("prio_load_led3", cnt[3], 255);
        check_eq("prio_load_led2", cnt[2], 255);
        pattern   = 8'h00;
        max_level = 8'h10;
        count_frame("clamp0", 0, 8'h00);
        check_eq("clamp0_led2", cnt[2], 255);
        count_frame("clamp1", 0, 8'h00);
        check_eq("clamp1_led2", cnt[2], 16);
        check_eq("clamp1_total", tot, 32);
        count_frame("clamp2", 0, 8'h00);
        check_eq("clamp2_total", tot, 0);

        // Mid-frame pattern change
        pattern    = 8'h01;
        max_level  = 8'h80;
        decay_step = 8'h00;
        count_frame("mid0", 0, 8'h00);
        check_eq("mid0_total", tot, 0);
        count_frame("mid1", 0, 8'h00);
        check_eq("mid1_led0", cnt[0], 128);
        count_frame("mid2", 64, 8'h02);
        check_eq("mid2_led0", cnt[0], 128);
        check_eq("mid2_led1", cnt[1], 0);
        count_frame("mid3", 0, 8'h00);
        check_eq("mid3_led0", cnt[0], 128);
        check_eq("mid3_led1", cnt[1], 128);

        // Reset mid-frame
        repeat (32) @(negedge clk);
        check_eq("pre_rst_led", led, 8'h03);
        rst     = 1'b1;
        pattern = 8'h00;
        @(negedge clk);
        check_eq("midrst_led", led, 0);
        check_eq("midrst_frame", frame, 0);
        rst = 1'b0;
        wait_first_frame(n_first, n_lit);
        check_eq("rst_rel_lat", n_first, 256);
        check_eq("rst_rel_dark", n_lit, 0);
        count_frame("rst_rel", 0, 8'h00);
        check_eq("rst_rel_total", tot, 0);

        // Enable drop mid-frame
        pattern = 8'h01;
        count_frame("en_pre0", 0, 8'h00);
        count_frame("en_pre1", 0, 8'h00);
        check_eq("en_pre1_led0", cnt[0], 128);
        repeat (32) @(negedge clk);
        check_eq("pre_en_led", led, 8'h01);
        en      = 1'b0;
        pattern = 8'h00;
        @(negedge clk);
        check_eq("en_off_led", led, 0);
        check_eq("en_off_frame", frame, 0);
        repeat (300) @(negedge clk);
        check_eq("en_off_hold_frame", frame, 0);
        en = 1'b1;
        wait_first_frame(n_first, n_lit);
        check_eq("en_rel_lat", n_first, 256);
        check_eq("en_rel_dark", n_lit, 0);
        count_frame("en_rel", 0, 8'h00);
        check_eq("en_rel_total", tot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
